// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and arithmetic helpers for the 3x3 streaming convolver
package conv_pkg;
  localparam int KADDR_CENTER = 4;
  localparam int KADDR_MAX = 8;
  localparam logic [KADDR_MAX:0] KERNEL_ID = 9'b1 << KADDR_CENTER;
  function automatic int acc_w(input int data_w, input int coef_w);
    return data_w + coef_w + 5;
  endfunction
  function automatic logic [63:0] sat_shift(input logic signed [63:0] acc, input int shift, input int data_w);
    logic signed [63:0] s, mx;
    s = acc >>> shift;
    mx = (64'sd1 <<< data_w) - 64'sd1;
    return s < 0 ? 64'd0 : s > mx ? mx : s;
  endfunction
endpackage

// File: rtl/conv3x3_stream_line_delay.sv
// line_delay: enabled shift register that bridges the gap between two window rows
module line_delay #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] sr_q [DEPTH];
  logic [DATA_W-1:0] sr_d [DEPTH];
  always_comb begin
    sr_d[0] = en ? d : sr_q[0];
    for (int i = 1; i < DEPTH; i++) sr_d[i] = en ? sr_q[i-1] : sr_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '{default: '0};
    else sr_q <= sr_d;
  end
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-order 3x3 convolution with run-time kernel and frame-synchronous commit
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_eof
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DEPTH = IMG_W - 3;
  logic [RW-1:0] row_q, row_d, pos_r;
  logic [CW-1:0] col_q, col_d, pos_c;
  logic signed [COEF_W-1:0] shd_q [9];
  logic signed [COEF_W-1:0] shd_d [9];
  logic signed [COEF_W-1:0] krn_q [9];
  logic signed [COEF_W-1:0] krn_d [9];
  logic [DATA_W-1:0] r0_q [2];
  logic [DATA_W-1:0] r0_d [2];
  logic [DATA_W-1:0] r1_q [3];
  logic [DATA_W-1:0] r1_d [3];
  logic [DATA_W-1:0] r2_q [3];
  logic [DATA_W-1:0] r2_d [3];
  logic [DATA_W-1:0] tap [9];
  logic [DATA_W-1:0] ld0_out, ld1_out;
  logic signed [PW-1:0] prod [9];
  logic signed [ACC_W-1:0] acc;
  logic last_col, at_origin, interior;
  logic out_valid_q, out_valid_d, out_eof_q, out_eof_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  // Each line delay plus its neighbouring window taps spans exactly one image row
  if (DEPTH > 0) begin : g_ld
    line_delay #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ld0 (
      .clk(clk), .rst(rst), .en(in_valid), .d(r0_q[1]), .q(ld0_out));
    line_delay #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ld1 (
      .clk(clk), .rst(rst), .en(in_valid), .d(r1_q[2]), .q(ld1_out));
  end else begin : g_nold
    assign ld0_out = r0_q[1];
    assign ld1_out = r1_q[2];
  end
  always_comb begin
    pos_r = in_sof ? '0 : row_q;
    pos_c = in_sof ? '0 : col_q;
    last_col = pos_c == CW'(IMG_W - 1);
    at_origin = pos_r == '0 && pos_c == '0;
    interior = in_valid && pos_r >= RW'(2) && pos_c >= CW'(2);
    col_d = !in_valid ? col_q : last_col ? '0 : pos_c + 1'b1;
    row_d = !in_valid ? row_q : !last_col ? pos_r : pos_r == RW'(IMG_H - 1) ? '0 : pos_r + 1'b1;
    for (int k = 0; k <= KADDR_MAX; k++) begin
      shd_d[k] = (coef_we && coef_addr == 4'(k)) ? coef_data : shd_q[k];
      krn_d[k] = (in_valid && at_origin) ? shd_q[k] : krn_q[k];
    end
    r0_d[0] = in_valid ? in_data : r0_q[0];
    r0_d[1] = in_valid ? r0_q[0] : r0_q[1];
    r1_d[0] = in_valid ? ld0_out : r1_q[0];
    r2_d[0] = in_valid ? ld1_out : r2_q[0];
    for (int j = 1; j < 3; j++) begin
      r1_d[j] = in_valid ? r1_q[j-1] : r1_q[j];
      r2_d[j] = in_valid ? r2_q[j-1] : r2_q[j];
    end
    tap[0] = in_data;
    tap[1] = r0_q[0];
    tap[2] = r0_q[1];
    for (int j = 0; j < 3; j++) begin
      tap[3+j] = r1_q[j];
      tap[6+j] = r2_q[j];
    end
    acc = '0;
    for (int k = 0; k <= KADDR_MAX; k++) begin
      prod[k] = PW'(signed'({1'b0, tap[k]})) * PW'(krn_q[k]);
      acc = acc + ACC_W'(prod[k]);
    end
    out_valid_d = interior;
    out_eof_d = interior && pos_r == RW'(IMG_H - 1) && last_col;
    out_data_d = interior ? DATA_W'(sat_shift(64'(acc), SHIFT, DATA_W)) : out_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      for (int k = 0; k <= KADDR_MAX; k++) begin
        shd_q[k] <= COEF_W'(KERNEL_ID[k]);
        krn_q[k] <= COEF_W'(KERNEL_ID[k]);
      end
      r0_q <= '{default: '0};
      r1_q <= '{default: '0};
      r2_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_eof_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      shd_q <= shd_d;
      krn_q <= krn_d;
      r0_q <= r0_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      out_valid_q <= out_valid_d;
      out_eof_q <= out_eof_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_eof = out_eof_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed checks of the 3x3 convolver on 9x9 frames
module tb_conv3x3_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_sof = 1'b0;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic out_valid, out_eof, out_valid3, out_eof3;
  logic [7:0] out_data, out_data3;
  int n_tests = 0, n_fail = 0, n_out = 0, br = 0, bc = 0;
  logic [7:0] last = '0;
  always #5 clk = ~clk;
  conv3x3_stream #(.DATA_W(8), .COEF_W(8), .IMG_W(9), .IMG_H(9), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .out_eof(out_eof));
  conv3x3_stream #(.DATA_W(8), .COEF_W(8), .IMG_W(9), .IMG_H(9), .SHIFT(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid3), .out_data(out_data3), .out_eof(out_eof3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // One clock: drive at the falling edge, check the registered result at the next falling edge
  task automatic step(input logic v, input logic [7:0] d, input logic sof,
                      input logic [7:0] e, input logic [7:0] e3, input bit c3);
    logic iv, ee;
    in_valid = v;
    in_data = d;
    in_sof = sof;
    iv = 1'b0;
    ee = 1'b0;
    if (v) begin
      if (sof) begin
        br = 0;
        bc = 0;
      end
      iv = br >= 2 && bc >= 2;
      ee = iv && br == 8 && bc == 8;
      if (bc == 8) begin
        bc = 0;
        br = br == 8 ? 0 : br + 1;
      end else bc++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    chk("out_valid", out_valid, iv);
    chk("out_eof", out_eof, ee);
    if (iv) last = e;
    chk("out_data", out_data, last);
    if (iv && c3) chk("s3_data", out_data3, e3);
    if (out_valid) n_out++;
  endtask
  task automatic wr_coef(input int a, input int d);
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    step(0, 0, 0, 0, 0, 0);
    coef_we = 1'b0;
  endtask
  task automatic load_all(input int d);
    for (int a = 0; a < 9; a++) wr_coef(a, d);
  endtask
  // kind 0: ramp, identity; kind 1: constant pv -> ev; kind 2: ramp with K00=3, K11=1
  task automatic frame(input int kind, input int pv, input int ev, input int ev3, input bit c3,
                       input bit stall, input int i0, input int i1, input bit sof0);
    for (int i = i0; i < i1; i++) begin
      int r, c, d, e;
      r = i / 9;
      c = i % 9;
      d = kind == 1 ? pv : 10 * r + c;
      e = kind == 0 ? 10 * (r - 1) + (c - 1) : kind == 2 ? 40 * r + 4 * c - 11 : ev;
      while (stall && $urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0, 0);
      step(1, 8'(d), sof0 && i == i0, 8'(e), 8'(ev3), c3);
    end
  endtask
  task automatic frame_end(input string tag);
    chk(tag, n_out, 49);
    n_out = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_eof", out_eof, 0);
    rst = 1'b0;
    frame(0, 0, 0, 0, 0, 0, 0, 81, 0);
    frame_end("s1_count");
    frame(0, 0, 0, 0, 0, 0, 0, 40, 0);
    load_all(1);
    wr_coef(9, 100);
    wr_coef(13, 100);
    frame(0, 0, 0, 0, 0, 0, 40, 81, 0);
    frame_end("s2_old_kernel_count");
    frame(1, 1, 9, 0, 0, 0, 0, 81, 0);
    frame_end("s2_ones_count");
    frame(1, 255, 255, 0, 0, 0, 0, 81, 0);
    frame_end("s3_sat_high_count");
    load_all(-1);
    frame(1, 255, 0, 0, 0, 0, 0, 81, 0);
    frame_end("s3_sat_low_count");
    load_all(1);
    frame(1, 8, 72, 9, 1, 0, 0, 81, 0);
    frame_end("s3_shift_count");
    for (int a = 0; a < 9; a++) wr_coef(a, a == 4 ? 1 : 0);
    frame(0, 0, 0, 0, 0, 1, 0, 81, 0);
    frame_end("s4_stall_count");
    frame(0, 0, 0, 0, 0, 0, 0, 40, 0);
    n_out = 0;
    frame(0, 0, 0, 0, 0, 0, 0, 81, 1);
    frame_end("s5_restart_count");
    wr_coef(0, 3);
    frame(2, 0, 0, 0, 0, 0, 0, 30, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("s6_rst_valid", out_valid, 0);
    chk("s6_rst_data", out_data, 0);
    chk("s6_rst_eof", out_eof, 0);
    br = 0;
    bc = 0;
    last = '0;
    n_out = 0;
    frame(0, 0, 0, 0, 0, 0, 0, 81, 0);
    frame_end("s6_identity_count");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
